// File: rtl/vga_sync_gen.sv
`default_nettype none
// ============================================================================
// vga_sync_gen : parametrised VGA raster timing generator (position, sync,
//                blanking, line/frame strobes).          Rev 1.0
// ============================================================================
module vga_sync_gen #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33,
  parameter bit H_SYNC_POL = 1'b0,
  parameter bit V_SYNC_POL = 1'b0,
  parameter int CNT_W      = 10,
  parameter int FRAME_W    = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pix_en,
  output logic [CNT_W-1:0]   hpos,
  output logic [CNT_W-1:0]   vpos,
  output logic               hsync,
  output logic               vsync,
  output logic               display_on,
  output logic               line_start,
  output logic               frame_start,
  output logic [FRAME_W-1:0] frame_cnt
);

  localparam int c_H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int c_V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  // Inclusive last-values so that no constant ever needs to hold 2^CNT_W.
  localparam logic [CNT_W-1:0] c_H_LAST     = CNT_W'(c_H_TOTAL - 1);
  localparam logic [CNT_W-1:0] c_V_LAST     = CNT_W'(c_V_TOTAL - 1);
  localparam logic [CNT_W-1:0] c_H_ACT_LAST = CNT_W'(H_ACTIVE - 1);
  localparam logic [CNT_W-1:0] c_V_ACT_LAST = CNT_W'(V_ACTIVE - 1);
  localparam logic [CNT_W-1:0] c_HS_FIRST   = CNT_W'(H_ACTIVE + H_FRONT);
  localparam logic [CNT_W-1:0] c_HS_LAST    = CNT_W'(H_ACTIVE + H_FRONT + H_SYNC - 1);
  localparam logic [CNT_W-1:0] c_VS_FIRST   = CNT_W'(V_ACTIVE + V_FRONT);
  localparam logic [CNT_W-1:0] c_VS_LAST    = CNT_W'(V_ACTIVE + V_FRONT + V_SYNC - 1);

  generate
    if ((c_H_TOTAL > (1 << CNT_W)) || (c_V_TOTAL > (1 << CNT_W))) begin : g_bad_cnt_w
      $error("vga_sync_gen: CNT_W too narrow for H_TOTAL/V_TOTAL");
    end
  endgenerate

  logic             w_h_last;
  logic             w_v_last;
  logic [CNT_W-1:0] w_h_next;
  logic [CNT_W-1:0] w_v_next;
  logic             w_hs_act;
  logic             w_vs_act;
  logic             w_de_next;

  // Sync/blank are derived from the next position so they land with it.
  always_comb begin
    w_h_last  = (hpos == c_H_LAST);
    w_v_last  = (vpos == c_V_LAST);
    w_h_next  = w_h_last ? '0 : hpos + CNT_W'(1);
    w_v_next  = vpos;
    if (w_h_last) begin
      w_v_next = w_v_last ? '0 : vpos + CNT_W'(1);
    end
    w_hs_act  = (w_h_next >= c_HS_FIRST) && (w_h_next <= c_HS_LAST);
    w_vs_act  = (w_v_next >= c_VS_FIRST) && (w_v_next <= c_VS_LAST);
    w_de_next = (w_h_next <= c_H_ACT_LAST) && (w_v_next <= c_V_ACT_LAST);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hpos        <= c_H_LAST;
      vpos        <= c_V_LAST;
      hsync       <= ~H_SYNC_POL;
      vsync       <= ~V_SYNC_POL;
      display_on  <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_cnt   <= '0;
    end else if (pix_en) begin
      hpos        <= w_h_next;
      vpos        <= w_v_next;
      hsync       <= w_hs_act ? H_SYNC_POL : ~H_SYNC_POL;
      vsync       <= w_vs_act ? V_SYNC_POL : ~V_SYNC_POL;
      display_on  <= w_de_next;
      line_start  <= w_h_last;
      frame_start <= w_h_last && w_v_last;
      if (w_h_last && w_v_last) begin
        frame_cnt <= frame_cnt + FRAME_W'(1);
      end
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vga_sync_gen.sv
`default_nettype none
// ============================================================================
// tb_vga_sync_gen : directed bench for default, short-frame and tiny modes.
//                                                         Rev 1.0
// ============================================================================
module tb_vga_sync_gen;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic en_d  = 1'b0;
  logic en_m  = 1'b0;
  logic en_s  = 1'b0;

  always #5 clk = ~clk;

  logic [9:0] d_h, d_v;
  logic       d_hs, d_vs, d_de, d_ls, d_fs;
  logic [7:0] d_fc;
  logic [9:0] m_h, m_v;
  logic       m_hs, m_vs, m_de, m_ls, m_fs;
  logic [7:0] m_fc;
  logic [2:0] s_h, s_v;
  logic       s_hs, s_vs, s_de, s_ls, s_fs;
  logic [1:0] s_fc;

  int checks = 0;
  int errors = 0;

  vga_sync_gen u_def (
    .clk(clk), .rst_n(rst_n), .pix_en(en_d),
    .hpos(d_h), .vpos(d_v), .hsync(d_hs), .vsync(d_vs), .display_on(d_de),
    .line_start(d_ls), .frame_start(d_fs), .frame_cnt(d_fc)
  );

  // Default horizontal timing, 7-line frame (vsync on lines 4..5).
  vga_sync_gen #(
    .V_ACTIVE(3), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)
  ) u_mid (
    .clk(clk), .rst_n(rst_n), .pix_en(en_m),
    .hpos(m_h), .vpos(m_v), .hsync(m_hs), .vsync(m_vs), .display_on(m_de),
    .line_start(m_ls), .frame_start(m_fs), .frame_cnt(m_fc)
  );

  // 8x6 raster, active-high syncs, CNT_W exactly fills H_TOTAL.
  vga_sync_gen #(
    .H_ACTIVE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_ACTIVE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1), .CNT_W(3), .FRAME_W(2)
  ) u_sml (
    .clk(clk), .rst_n(rst_n), .pix_en(en_s),
    .hpos(s_h), .vpos(s_v), .hsync(s_hs), .vsync(s_vs), .display_on(s_de),
    .line_start(s_ls), .frame_start(s_fs), .frame_cnt(s_fc)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // which: 0 = u_def, 1 = u_mid, 2 = u_sml; the others hold.
  task automatic tick(input int which, input logic en);
    en_d = (which == 0) ? en : 1'b0;
    en_m = (which == 1) ? en : 1'b0;
    en_s = (which == 2) ? en : 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic adv(input int which, input int n);
    repeat (n) tick(which, 1'b1);
  endtask

  task automatic chk_d(input string t, input int h, input int v, input int hs, input int vs,
                       input int de, input int ls, input int fs, input int fc);
    chk({t, ".hpos"}, d_h, h);   chk({t, ".vpos"}, d_v, v);
    chk({t, ".hsync"}, d_hs, hs); chk({t, ".vsync"}, d_vs, vs);
    chk({t, ".de"}, d_de, de);   chk({t, ".ls"}, d_ls, ls);
    chk({t, ".fs"}, d_fs, fs);   chk({t, ".fcnt"}, d_fc, fc);
  endtask

  task automatic chk_s(input string t, input int h, input int v, input int hs, input int vs,
                       input int de, input int ls, input int fs, input int fc);
    chk({t, ".hpos"}, s_h, h);   chk({t, ".vpos"}, s_v, v);
    chk({t, ".hsync"}, s_hs, hs); chk({t, ".vsync"}, s_vs, vs);
    chk({t, ".de"}, s_de, de);   chk({t, ".ls"}, s_ls, ls);
    chk({t, ".fs"}, s_fs, fs);   chk({t, ".fcnt"}, s_fc, fc);
  endtask

  initial begin
    int vs_cnt, first_i, last_i, fs_cnt, fs_at;
    logic [7:0] hs_tab, de_tab;

    // ---- reset and idle hold ----
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_d("rst", 799, 524, 1, 1, 0, 0, 0, 0);
    chk("rst.mid.vpos", m_v, 6);
    chk_s("rst.sml", 7, 5, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(0, 1'b0);
      chk_d("hold", 799, 524, 1, 1, 0, 0, 0, 0);
    end

    // ---- default mode, first line ----
    tick(0, 1'b1); chk_d("first", 0, 0, 1, 1, 1, 1, 1, 1);
    tick(0, 1'b1); chk_d("h1", 1, 0, 1, 1, 1, 0, 0, 1);
    adv(0, 638);   chk_d("h639", 639, 0, 1, 1, 1, 0, 0, 1);
    adv(0, 1);     chk_d("h640", 640, 0, 1, 1, 0, 0, 0, 1);
    adv(0, 15);    chk_d("h655", 655, 0, 1, 1, 0, 0, 0, 1);
    adv(0, 1);     chk_d("h656", 656, 0, 0, 1, 0, 0, 0, 1);
    adv(0, 95);    chk_d("h751", 751, 0, 0, 1, 0, 0, 0, 1);
    adv(0, 1);     chk_d("h752", 752, 0, 1, 1, 0, 0, 0, 1);
    adv(0, 47);    chk_d("h799", 799, 0, 1, 1, 0, 0, 0, 1);
    adv(0, 1);     chk_d("line1", 0, 1, 1, 1, 1, 1, 0, 1);

    // ---- pix_en toggling: freeze and one-clk strobes ----
    tick(0, 1'b0); chk_d("tog0", 0, 1, 1, 1, 1, 0, 0, 1);
    tick(0, 1'b1); chk_d("tog1", 1, 1, 1, 1, 1, 0, 0, 1);
    tick(0, 1'b0); chk_d("tog2", 1, 1, 1, 1, 1, 0, 0, 1);
    tick(0, 1'b1); chk_d("tog3", 2, 1, 1, 1, 1, 0, 0, 1);
    adv(0, 797);   chk_d("h799v1", 799, 1, 1, 1, 0, 0, 0, 1);
    tick(0, 1'b1); chk_d("line2", 0, 2, 1, 1, 1, 1, 0, 1);
    tick(0, 1'b0); chk_d("line2.hold", 0, 2, 1, 1, 1, 0, 0, 1);

    // ---- mid-frame reset overrides pix_en ----
    adv(0, 300);   chk_d("h300", 300, 2, 1, 1, 1, 0, 0, 1);
    rst_n = 1'b0;
    tick(0, 1'b1); chk_d("midrst", 799, 524, 1, 1, 0, 0, 0, 0);
    rst_n = 1'b1;
    tick(0, 1'b1); chk_d("refirst", 0, 0, 1, 1, 1, 1, 1, 1);

    // ---- full short frame: vsync width and frame recurrence ----
    tick(1, 1'b1);
    chk("mid.first.fs", m_fs, 1); chk("mid.first.fcnt", m_fc, 1);
    chk("mid.first.vsync", m_vs, 1);
    vs_cnt = 0; first_i = 0; last_i = 0; fs_cnt = 0; fs_at = 0;
    for (int i = 1; i <= 5600; i++) begin
      tick(1, 1'b1);
      if (m_vs == 1'b0) begin
        vs_cnt++;
        if (first_i == 0) first_i = i;
        last_i = i;
      end
      if (m_fs == 1'b1) begin
        fs_cnt++;
        fs_at = i;
      end
    end
    chk("mid.vs_low_cnt", vs_cnt, 1600);
    chk("mid.vs_first", first_i, 3200);
    chk("mid.vs_last", last_i, 4799);
    chk("mid.fs_cnt", fs_cnt, 1);
    chk("mid.fs_at", fs_at, 5600);
    chk("mid.hpos", m_h, 0); chk("mid.vpos", m_v, 0);
    chk("mid.fcnt", m_fc, 2);

    // ---- tiny mode: positive syncs and frame counter wrap ----
    tick(2, 1'b1); chk_s("sml.first", 0, 0, 0, 0, 1, 1, 1, 1);
    hs_tab = 8'b0110_0000;
    de_tab = 8'b0000_1111;
    for (int h = 1; h < 8; h++) begin
      tick(2, 1'b1);
      chk("sml.hpos", s_h, h);
      chk("sml.hsync", s_hs, hs_tab[h]);
      chk("sml.de", s_de, de_tab[h]);
      chk("sml.ls", s_ls, 0);
    end
    adv(2, 41);    chk_s("sml.f2", 0, 0, 0, 0, 1, 1, 1, 2);
    vs_cnt = 0; first_i = 0; fs_cnt = 0;
    for (int i = 1; i <= 48; i++) begin
      tick(2, 1'b1);
      if (s_vs == 1'b1) begin
        vs_cnt++;
        if (first_i == 0) first_i = i;
      end
      if (s_fs == 1'b1) fs_cnt++;
    end
    chk("sml.vs_high_cnt", vs_cnt, 8);
    chk("sml.vs_first", first_i, 32);
    chk("sml.fs_cnt", fs_cnt, 1);
    chk("sml.f3.fcnt", s_fc, 3);
    adv(2, 48);    chk_s("sml.wrap", 0, 0, 0, 0, 1, 1, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
